uart_tx_fifo: RTL and testbench
===============================

// Module: uart_tx_fifo
// PURPOSE
//  Byte buffer and frame pacer between ctrl_uart (producer) and tx_uart (consumer).
//  Absorbs back-to-back result bytes from ctrl_uart and replays them to tx_uart.
//  Each replay is a one-cycle tx_ready strobe. Consecutive strobes are spaced exactly
//  one UART frame plus guard bits apart, so tx_uart never receives a strobe mid-frame.
// PARAMETERS
//  CLK_FREQ   50_000_000  system clock frequency, Hz
//  BAUD       9600        line rate; BIT_CYC = CLK_FREQ/BAUD (integer division)
//  GAP_BITS   1           idle bit-times appended after each 10-bit frame
//  DEPTH      16          FIFO entries, power of two, >= 2
//  Derived: FRAME_CYC = BIT_CYC*(10+GAP_BITS); must be >= 2 (default 57288)
// PORTS
//  clk       in   1          system clock, rising edge
//  rst       in   1          asynchronous reset, active-high
//  wr_en     in   1          write strobe (ctrl_uart tx_ready), one byte per high cycle
//  wr_data   in   8          byte to enqueue, sampled when wr_en=1
//  ovf_clr   in   1          synchronous clear of the overflow flag
//  tx_ready  out  1          one-cycle launch strobe to tx_uart
//  tx_data   out  8          byte for tx_uart; held stable from strobe until next strobe
//  count     out  log2(DEPTH)+1  current occupancy, 0..DEPTH
//  empty     out  1          count==0
//  full      out  1          count==DEPTH
//  overflow  out  1          sticky; set on a write that did not enter normally
//  idle      out  1          empty && state==IDLE (all bytes handed to tx_uart)
// BEHAVIOUR
//  Reset (async, rst=1): ptrs=0, count=0, state=IDLE, tx_ready=0, tx_data=8'h00,
//   overflow=0, wait counter=0. Reset mid-WAIT aborts pacing; queued bytes are lost.
//  Storage: circular buffer, wr_ptr/rd_ptr wrap modulo DEPTH, count tracked explicitly.
//  FSM states:
//   IDLE: on an edge with count!=0: tx_data<=mem[rd_ptr], tx_ready<=1, rd_ptr++,
//    count--, wcnt<=FRAME_CYC-2, state<=WAIT.
//    Pop sees only bytes present before that edge. A write on the same edge into an
//    empty FIFO is not popped.
//   WAIT: tx_ready<=0. When wcnt==0: state<=IDLE. Otherwise wcnt--.
//  Latency: byte written at edge k into empty FIFO with state IDLE -> tx_ready high
//   in the cycle after edge k+1.
//  Pacing: while data is queued, strobes recur every exactly FRAME_CYC cycles.
//  Simultaneous pop and write on one edge: both occur; count unchanged.
//   This holds even when full: the pop frees a slot, the write is accepted,
//   and overflow is not set.
//  Write while full, no pop: the byte does not enter normally and overflow<=1
//   (see CONFIGURATION). count stays DEPTH.
//  overflow: set has priority over ovf_clr on the same edge. Cleared only by ovf_clr or rst.
//  tx_data is never modified except on a pop.
// CONFIGURATION
//  TXFIFO_DROP_OLDEST_EN undefined: write while full is discarded; contents unchanged.
//  TXFIFO_DROP_OLDEST_EN defined: write while full overwrites the oldest entry.
//   mem[rd_ptr]<=wr_data, rd_ptr++, wr_ptr++, count stays DEPTH.
//   Newest data is kept. overflow is still set.
// TESTING  (short runs use CLK_FREQ=1000, BAUD=100, GAP_BITS=1 -> FRAME_CYC=110)
//  1 Single byte 0x73 at edge k from reset-idle -> tx_ready high one cycle after
//    edge k+1, tx_data=0x73, count 1->0. idle goes high after 110 cycles.
//  2 Burst 0x73,0x03,0x74,0x03 on 4 consecutive edges -> 4 strobes in order.
//    Strobe spacing is exactly 110 cycles. tx_data holds each value between strobes.
//    No overflow.
//  3 DEPTH=4, writes 0x10..0x16 on edges 0..6, default build -> count peaks at 4.
//    Output is 0x10,0x11,0x12,0x13,0x14. overflow=1 after edge 5.
//  4 Same stimulus, TXFIFO_DROP_OLDEST_EN defined -> output is 0x10,0x13,0x14,0x15,0x16.
//    overflow=1.
//  5 DEPTH=4 full, write coinciding with pop edge -> byte accepted, count stays 4,
//    overflow stays 0. Then ovf_clr after an earlier overflow -> overflow=0 next cycle.
//  6 Queue 3 bytes, assert rst mid-WAIT -> outputs immediately at reset values,
//    count=0, no further strobes. A new write after release launches normally.

Source files
------------

// File: rtl/uart_tx_fifo_if.sv
// Byte-stream bundle between ctrl_uart (writer), the tx FIFO/pacer and tx_uart.
// Pure wiring, no latency of its own.
// No backpressure: the writer learns of a lost byte only through overflow.
interface uart_tx_fifo_if #(
  parameter int DEPTH = 16
);
  logic                    wr_en;
  logic [7:0]              wr_data;
  logic                    ovf_clr;
  logic                    tx_ready;
  logic [7:0]              tx_data;
  logic [$clog2(DEPTH):0]  count;
  logic                    empty;
  logic                    full;
  logic                    overflow;
  logic                    idle;

  // Producer side: pushes bytes, clears the overflow flag, watches status.
  modport master (
    output wr_en, wr_data, ovf_clr,
    input  tx_ready, tx_data, count, empty, full, overflow, idle
  );

  // FIFO side: consumes writes, emits paced launch strobes and status.
  modport slave (
    input  wr_en, wr_data, ovf_clr,
    output tx_ready, tx_data, count, empty, full, overflow, idle
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO that replays queued bytes to tx_uart as one-cycle strobes spaced one frame apart.
// Latency: write at edge k into an empty idle FIFO -> tx_ready high in the cycle after edge k+1.
// No backpressure: a write while full (without a same-edge pop) raises sticky overflow.
// Optional build macro TXFIFO_DROP_OLDEST_EN: a write while full overwrites the oldest entry.
module uart_tx_fifo #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 9600,
  parameter int GAP_BITS = 1,
  parameter int DEPTH    = 16
) (
  input logic           clk,
  input logic           rst,
  uart_tx_fifo_if.slave bus
);

  localparam int BIT_CYC   = CLK_FREQ / BAUD;
  localparam int FRAME_CYC = BIT_CYC * (10 + GAP_BITS);
  localparam int AW        = $clog2(DEPTH);
  localparam int CW        = AW + 1;
  localparam int WW        = $clog2(FRAME_CYC);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t         state, state_nxt;
  logic [7:0]     mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  cnt;
  logic [WW-1:0]  wcnt;
  logic           tx_ready_q;
  logic [7:0]     tx_data_q;
  logic           ovf_q;

  logic           pop;
  logic           wcnt_dec;
  logic           full_now;
  logic           push;
  logic           ovf_evt;

  assign full_now = (cnt == CW'(DEPTH));
  // A pop on the same edge frees a slot, so a write into a full FIFO is still accepted.
  assign push     = bus.wr_en && (!full_now || pop);
  assign ovf_evt  = bus.wr_en && full_now && !pop;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next state: IDLE launches a byte whenever one was already queued; WAIT burns a frame.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    wcnt_dec  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (cnt != '0) begin
          pop       = 1'b1;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (wcnt == '0) state_nxt = S_IDLE;
        else            wcnt_dec  = 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Storage array; no reset needed since count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.wr_data;
    end
`ifdef TXFIFO_DROP_OLDEST_EN
    else if (ovf_evt) begin
      // Full means wr_ptr == rd_ptr, so this replaces the oldest byte.
      mem[rd_ptr] <= bus.wr_data;
    end
`endif
  end

  // Pointers, occupancy, frame counter, launch strobe and overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
      wcnt       <= '0;
      tx_ready_q <= 1'b0;
      tx_data_q  <= 8'h00;
      ovf_q      <= 1'b0;
    end else begin
      tx_ready_q <= pop;
      if (pop) begin
        tx_data_q <= mem[rd_ptr];
        rd_ptr    <= rd_ptr + AW'(1);
        // Strobe cycle plus FRAME_CYC-2 countdown plus the zero-detect cycle = one frame.
        wcnt      <= WW'(FRAME_CYC - 2);
      end else if (wcnt_dec) begin
        wcnt <= wcnt - WW'(1);
      end
      if (push) wr_ptr <= wr_ptr + AW'(1);
`ifdef TXFIFO_DROP_OLDEST_EN
      if (ovf_evt) begin
        wr_ptr <= wr_ptr + AW'(1);
        rd_ptr <= rd_ptr + AW'(1);
      end
`endif
      unique case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
      // Setting wins over clearing so a same-edge loss is never hidden.
      if (ovf_evt)          ovf_q <= 1'b1;
      else if (bus.ovf_clr) ovf_q <= 1'b0;
    end
  end

  assign bus.tx_ready = tx_ready_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.count    = cnt;
  assign bus.empty    = (cnt == '0);
  assign bus.full     = full_now;
  assign bus.overflow = ovf_q;
  assign bus.idle     = (cnt == '0) && (state == S_IDLE);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed writes, expected strobes queued with their cycle,
// a negedge monitor pops and compares data, timing and tx_data hold between strobes.
module tb_uart_tx_fifo;
  localparam int DEPTH = 4;
  localparam int FRAME = 110;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   k;
  logic [7:0] last_dat = 8'h00;

  typedef struct {
    logic [7:0] d;
    int         c;
  } exp_t;
  exp_t sb[$];

  logic [7:0] b2 [4] = '{8'h73, 8'h03, 8'h74, 8'h03};
  int         c3 [7] = '{1, 1, 2, 3, 4, 4, 4};
  int         o3 [7] = '{0, 0, 0, 0, 0, 1, 1};
`ifdef TXFIFO_DROP_OLDEST_EN
  logic [7:0] e3 [5] = '{8'h10, 8'h13, 8'h14, 8'h15, 8'h16};
  logic [7:0] e5 [6] = '{8'h20, 8'h21, 8'h24, 8'h25, 8'h26, 8'h27};
`else
  logic [7:0] e3 [5] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
  logic [7:0] e5 [6] = '{8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25};
`endif

  uart_tx_fifo_if #(.DEPTH(DEPTH)) bus ();

  uart_tx_fifo #(
    .CLK_FREQ(1000),
    .BAUD    (100),
    .GAP_BITS(1),
    .DEPTH   (DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic we, input logic [7:0] d, input logic clr);
    bus.wr_en   = we;
    bus.wr_data = d;
    bus.ovf_clr = clr;
    step(1);
    bus.wr_en   = 1'b0;
    bus.ovf_clr = 1'b0;
  endtask

  task automatic expect_byte(input logic [7:0] d, input int c);
    exp_t e;
    e.d = d;
    e.c = c;
    sb.push_back(e);
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while ((sb.size() != 0 || bus.idle !== 1'b1) && t < 2000) begin
      step(1);
      t++;
    end
    chk({name, " drain"}, 32'((sb.size() == 0) && (bus.idle === 1'b1)), 32'd1);
  endtask

  // Monitor: every strobe must match the head of the scoreboard; tx_data holds otherwise.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      last_dat = 8'h00;
    end else if (bus.tx_ready === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected strobe", 32'(bus.tx_data), 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        chk("strobe data", 32'(bus.tx_data), 32'(e.d));
        chk("strobe cycle", 32'(cyc), 32'(e.c));
      end
      last_dat = bus.tx_data;
    end else begin
      chk("tx_data hold", 32'(bus.tx_data), 32'(last_dat));
    end
  end

  initial begin
    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;
    bus.ovf_clr = 1'b0;

    // Reset state
    step(3);
    chk("rst tx_ready", 32'(bus.tx_ready), 32'd0);
    chk("rst tx_data",  32'(bus.tx_data),  32'd0);
    chk("rst count",    32'(bus.count),    32'd0);
    chk("rst empty",    32'(bus.empty),    32'd1);
    chk("rst full",     32'(bus.full),     32'd0);
    chk("rst overflow", 32'(bus.overflow), 32'd0);
    chk("rst idle",     32'(bus.idle),     32'd1);
    rst = 1'b0;
    step(2);

    // Single byte: latency, pop, idle after one frame
    k = cyc + 1;
    expect_byte(8'h73, k + 1);
    drive(1'b1, 8'h73, 1'b0);
    chk("t1 count after write", 32'(bus.count), 32'd1);
    step(1);
    chk("t1 count after pop", 32'(bus.count), 32'd0);
    chk("t1 tx_ready", 32'(bus.tx_ready), 32'd1);
    step(108);
    chk("t1 idle before frame end", 32'(bus.idle), 32'd0);
    step(1);
    chk("t1 idle after frame", 32'(bus.idle), 32'd1);

    // Burst of four: exact frame spacing
    k = cyc + 1;
    for (int i = 0; i < 4; i++) expect_byte(b2[i], k + 1 + FRAME * i);
    for (int i = 0; i < 4; i++) drive(1'b1, b2[i], 1'b0);
    chk("t2 count", 32'(bus.count), 32'd3);
    drain("t2");
    chk("t2 overflow", 32'(bus.overflow), 32'd0);

    // Overfill a 4-deep FIFO with seven back-to-back writes
    k = cyc + 1;
    for (int i = 0; i < 5; i++) expect_byte(e3[i], k + 1 + FRAME * i);
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 8'(8'h10 + i), 1'b0);
      chk("t3 count", 32'(bus.count), 32'(c3[i]));
      chk("t3 overflow", 32'(bus.overflow), 32'(o3[i]));
    end
    chk("t3 full", 32'(bus.full), 32'd1);
    drain("t3");

    // Clear sticky overflow
    drive(1'b0, 8'h00, 1'b1);
    chk("t5 ovf_clr", 32'(bus.overflow), 32'd0);

    // Full FIFO with a write landing on the pop edge, then set-vs-clear priority
    k = cyc + 1;
    for (int i = 0; i < 6; i++) expect_byte(e5[i], k + 1 + FRAME * i);
    for (int i = 0; i < 5; i++) drive(1'b1, 8'(8'h20 + i), 1'b0);
    chk("t5 count full", 32'(bus.count), 32'd4);
    step(106);
    chk("t5 count before pop", 32'(bus.count), 32'd4);
    drive(1'b1, 8'h25, 1'b0);
    chk("t5 pop+write tx_ready", 32'(bus.tx_ready), 32'd1);
    chk("t5 pop+write count", 32'(bus.count), 32'd4);
    chk("t5 pop+write overflow", 32'(bus.overflow), 32'd0);
    drive(1'b1, 8'h26, 1'b0);
    chk("t5 overflow set", 32'(bus.overflow), 32'd1);
    chk("t5 count stays full", 32'(bus.count), 32'd4);
    drive(1'b1, 8'h27, 1'b1);
    chk("t5 set beats clear", 32'(bus.overflow), 32'd1);
    drive(1'b0, 8'h00, 1'b1);
    chk("t5 clear", 32'(bus.overflow), 32'd0);
    drain("t5");

    // Reset in the middle of pacing
    k = cyc + 1;
    expect_byte(8'h31, k + 1);
    drive(1'b1, 8'h31, 1'b0);
    drive(1'b1, 8'h32, 1'b0);
    drive(1'b1, 8'h33, 1'b0);
    step(20);
    rst = 1'b1;
    #1;
    chk("t6 rst tx_ready", 32'(bus.tx_ready), 32'd0);
    chk("t6 rst tx_data",  32'(bus.tx_data),  32'd0);
    chk("t6 rst count",    32'(bus.count),    32'd0);
    chk("t6 rst idle",     32'(bus.idle),     32'd1);
    chk("t6 rst empty",    32'(bus.empty),    32'd1);
    step(2);
    rst = 1'b0;
    step(250);
    chk("t6 count after release", 32'(bus.count), 32'd0);
    k = cyc + 1;
    expect_byte(8'h5A, k + 1);
    drive(1'b1, 8'h5A, 1'b0);
    drain("t6");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
